// File: rtl/output_vc_credit_ctrl_pkg.sv
// output_vc_credit_ctrl_pkg: shared types and default sizes for the output VC credit controller
package output_vc_credit_ctrl_pkg;
    typedef enum logic [1:0] {VC_FREE, VC_ACTIVE, VC_DRAIN} vc_state_e;
    localparam int DEF_NUM_PORTS = 5;
    localparam int DEF_NUM_VC = 4;
    localparam int DEF_CREDIT_DEPTH = 1;
    localparam int LOCAL_PORT = DEF_NUM_PORTS - 1;
endpackage

// File: rtl/output_vc_credit_ctrl_if.sv
// output_vc_credit_ctrl_if: allocation, send, credit-return and status signals of the controller
//   master: requester/router side (drives alloc_req, flit_send*, credit_in*)
//   slave:  controller side (drives alloc_gnt, alloc_vc, vc_availability, credit_ok, err_*)
interface output_vc_credit_ctrl_if #(
    parameter int NUM_PORTS = 5,
    parameter int NUM_VC = 4
);
    localparam int VC_BITS = $clog2(NUM_VC);
    logic [NUM_PORTS-1:0] alloc_req;
    logic [NUM_PORTS-1:0] alloc_gnt;
    logic [VC_BITS-1:0] alloc_vc [NUM_PORTS];
    logic [NUM_PORTS-1:0] flit_send;
    logic [VC_BITS-1:0] flit_send_vc [NUM_PORTS];
    logic [NUM_PORTS-1:0] flit_send_tail;
    logic [NUM_PORTS-2:0] credit_in;
    logic [VC_BITS-1:0] credit_in_vc [NUM_PORTS-1];
    logic [NUM_VC*NUM_PORTS-1:0] vc_availability;
    logic [NUM_VC*NUM_PORTS-1:0] credit_ok;
    logic err_overflow;
    logic err_underflow;
    modport master (
        output alloc_req, flit_send, flit_send_vc, flit_send_tail, credit_in, credit_in_vc,
        input alloc_gnt, alloc_vc, vc_availability, credit_ok, err_overflow, err_underflow
    );
    modport slave (
        input alloc_req, flit_send, flit_send_vc, flit_send_tail, credit_in, credit_in_vc,
        output alloc_gnt, alloc_vc, vc_availability, credit_ok, err_overflow, err_underflow
    );
endinterface

// File: rtl/output_vc_credit_ctrl_rr_arbiter.sv
// output_vc_credit_ctrl_rr_arbiter: round-robin pick of the first request at or after a held pointer
//   clk, reset        : clock, synchronous active-high reset (pointer -> 0)
//   req               : candidate vector
//   advance           : a grant was taken; pointer moves just past gnt_idx
//   gnt_onehot/idx/any: combinational pick from req and the registered pointer
module output_vc_credit_ctrl_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);
    logic [IW-1:0] ptr;
    logic [IW:0] s;
    // Scan from the far end back to ptr so the nearest request at or after ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (IW+1)'(i);
            s = (s >= (IW+1)'(NUM_REQ)) ? s - (IW+1)'(NUM_REQ) : s;
            if (req[s[IW-1:0]]) begin
                gnt_idx = s[IW-1:0];
                gnt_any = 1'b1;
            end
        end
        gnt_onehot = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (advance) ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/output_vc_credit_ctrl.sv
// output_vc_credit_ctrl: per-output-port downstream VC ownership, credit tracking and VC allocation
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of output_vc_credit_ctrl_if (alloc req/gnt/vc, flit send,
//                credit return, vc_availability, credit_ok, sticky err_overflow/err_underflow)
module output_vc_credit_ctrl
    import output_vc_credit_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int NUM_VC = DEF_NUM_VC,
    parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH
) (
    input logic clk,
    input logic reset,
    output_vc_credit_ctrl_if.slave bus
);
    localparam int VC_BITS = $clog2(NUM_VC);
    localparam int CRED_BITS = $clog2(CREDIT_DEPTH + 1);
    localparam int LOCAL = NUM_PORTS - 1;
    localparam logic [CRED_BITS-1:0] FULL = CRED_BITS'(CREDIT_DEPTH);
    vc_state_e vc_state [NUM_PORTS][NUM_VC];
    vc_state_e st_nxt [NUM_PORTS][NUM_VC];
    logic [CRED_BITS-1:0] credit_cnt [NUM_PORTS-1][NUM_VC];
    logic [CRED_BITS-1:0] cnt_nxt [NUM_PORTS][NUM_VC];
    logic [CRED_BITS-1:0] cnt_view [NUM_PORTS][NUM_VC];
    logic [NUM_VC*NUM_PORTS-1:0] avail, ok;
    logic [NUM_VC-1:0] gnt_vec [NUM_PORTS];
    logic [VC_BITS-1:0] gidx [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_any, ret_v;
    logic [VC_BITS-1:0] ret_vc [NUM_PORTS];
    logic hit, snd, tail, ret, ovf, unf, err_ovf, err_unf;
    logic [CRED_BITS-1:0] c;
    // The local (eject) port has no counter; it is viewed as permanently full.
    always_comb begin
        avail = '0;
        ok = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int v = 0; v < NUM_VC; v++) cnt_view[p][v] = FULL;
        for (int p = 0; p < NUM_PORTS - 1; p++)
            for (int v = 0; v < NUM_VC; v++) cnt_view[p][v] = credit_cnt[p][v];
        for (int p = 0; p < NUM_PORTS; p++)
            for (int v = 0; v < NUM_VC; v++) begin
                avail[p*NUM_VC+v] = vc_state[p][v] == VC_FREE && cnt_view[p][v] == FULL;
                ok[p*NUM_VC+v] = cnt_view[p][v] != '0;
            end
    end
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_arb
        output_vc_credit_ctrl_rr_arbiter #(.NUM_REQ(NUM_VC)) u_arb (
            .clk(clk),
            .reset(reset),
            .req(avail[p*NUM_VC +: NUM_VC]),
            .advance(bus.alloc_gnt[p]),
            .gnt_onehot(gnt_vec[p]),
            .gnt_idx(gidx[p]),
            .gnt_any(gnt_any[p])
        );
    end
    assign bus.alloc_gnt = bus.alloc_req & gnt_any & {NUM_PORTS{~reset}};
    assign bus.alloc_vc = gidx;
    assign bus.vc_availability = avail;
    assign bus.credit_ok = ok;
    assign bus.err_overflow = err_ovf;
    assign bus.err_underflow = err_unf;
    // A send to a FREE VC (including one being granted this cycle) is rejected as underflow.
    // DRAIN frees on the post-update count, so a returning credit frees the VC at the same edge.
    always_comb begin
        ovf = 1'b0;
        unf = 1'b0;
        hit = 1'b0;
        snd = 1'b0;
        tail = 1'b0;
        ret = 1'b0;
        c = '0;
        st_nxt = vc_state;
        cnt_nxt = cnt_view;
        ret_v = {1'b0, bus.credit_in};
        for (int p = 0; p < NUM_PORTS; p++) ret_vc[p] = '0;
        for (int p = 0; p < NUM_PORTS - 1; p++) ret_vc[p] = bus.credit_in_vc[p];
        for (int p = 0; p < NUM_PORTS; p++)
            for (int v = 0; v < NUM_VC; v++) begin
                hit = bus.flit_send[p] && bus.flit_send_vc[p] == VC_BITS'(v);
                unf = unf | (hit && vc_state[p][v] == VC_FREE);
                snd = hit && vc_state[p][v] != VC_FREE;
                tail = snd && bus.flit_send_tail[p];
                ret = ret_v[p] && ret_vc[p] == VC_BITS'(v);
                c = cnt_view[p][v];
                if (p != LOCAL) begin
                    unf = unf | (snd && c == '0);
                    ovf = ovf | (ret && c == FULL);
                    c = (snd && !ret && c != '0) ? c - 1'b1 : (ret && !snd && c != FULL) ? c + 1'b1 : c;
                end
                cnt_nxt[p][v] = c;
                st_nxt[p][v] = (vc_state[p][v] == VC_FREE && gnt_vec[p][v] && bus.alloc_gnt[p]) ? VC_ACTIVE :
                               (vc_state[p][v] == VC_ACTIVE && tail) ? ((p == LOCAL) ? VC_FREE : VC_DRAIN) :
                               (vc_state[p][v] == VC_DRAIN && c == FULL) ? VC_FREE : vc_state[p][v];
            end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++)
                for (int v = 0; v < NUM_VC; v++) vc_state[p][v] <= VC_FREE;
            for (int p = 0; p < NUM_PORTS - 1; p++)
                for (int v = 0; v < NUM_VC; v++) credit_cnt[p][v] <= FULL;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            vc_state <= st_nxt;
            for (int p = 0; p < NUM_PORTS - 1; p++)
                for (int v = 0; v < NUM_VC; v++) credit_cnt[p][v] <= cnt_nxt[p][v];
            err_ovf <= err_ovf | ovf;
            err_unf <= err_unf | unf;
        end
    end
endmodule

// File: tb/tb_output_vc_credit_ctrl.sv
// tb_output_vc_credit_ctrl: directed checks of allocation, credits, DRAIN, local eject and errors
module tb_output_vc_credit_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int passed = 0;
    int total = 0;
    always #5 clk = ~clk;
    output_vc_credit_ctrl_if #(.NUM_PORTS(5), .NUM_VC(4)) b ();
    output_vc_credit_ctrl_if #(.NUM_PORTS(5), .NUM_VC(4)) b2 ();
    output_vc_credit_ctrl #(.NUM_PORTS(5), .NUM_VC(4), .CREDIT_DEPTH(1)) dut (.clk(clk), .reset(reset), .bus(b));
    output_vc_credit_ctrl #(.NUM_PORTS(5), .NUM_VC(4), .CREDIT_DEPTH(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clr();
        b.alloc_req = '0; b.flit_send = '0; b.flit_send_tail = '0; b.credit_in = '0;
        b2.alloc_req = '0; b2.flit_send = '0; b2.flit_send_tail = '0; b2.credit_in = '0;
        for (int i = 0; i < 5; i++) begin b.flit_send_vc[i] = '0; b2.flit_send_vc[i] = '0; end
        for (int i = 0; i < 4; i++) begin b.credit_in_vc[i] = '0; b2.credit_in_vc[i] = '0; end
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        clr();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_avail", 32'(b.vc_availability), 32'hFFFFF);
        chk("reset_credit_ok", 32'(b.credit_ok), 32'hFFFFF);
        chk("reset_gnt", 32'(b.alloc_gnt), 0);
        chk("reset_errs", {30'd0, b.err_overflow, b.err_underflow}, 0);
        chk("reset_avail_d2", 32'(b2.vc_availability), 32'hFFFFF);
        b.alloc_req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("p0_gnt", 32'(b.alloc_gnt[0]), 1);
            chk("p0_vc", 32'(b.alloc_vc[0]), 32'(i));
            tick();
        end
        #1;
        chk("p0_gnt_exhausted", 32'(b.alloc_gnt[0]), 0);
        chk("p0_avail", 32'(b.vc_availability[3:0]), 0);
        clr();
        tick();
        b.alloc_req[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("p1_vc", 32'(b.alloc_vc[1]), 32'(i));
            tick();
        end
        clr();
        chk("p1_avail", 32'(b.vc_availability[7:4]), 32'b1000);
        chk("p1_ok_before", 32'(b.credit_ok[6]), 1);
        b.flit_send[1] = 1'b1; b.flit_send_vc[1] = 2'd2;
        tick(); clr();
        chk("p1_ok_after_body", 32'(b.credit_ok[6]), 0);
        b.credit_in[1] = 1'b1; b.credit_in_vc[1] = 2'd2;
        tick(); clr();
        chk("p1_ok_returned", 32'(b.credit_ok[6]), 1);
        chk("p1_still_active", 32'(b.vc_availability[6]), 0);
        b.flit_send[1] = 1'b1; b.flit_send_vc[1] = 2'd2; b.flit_send_tail[1] = 1'b1;
        tick(); clr();
        chk("p1_drain_ok", 32'(b.credit_ok[6]), 0);
        chk("p1_drain_avail", 32'(b.vc_availability[6]), 0);
        chk("p1_no_underflow", 32'(b.err_underflow), 0);
        b.credit_in[1] = 1'b1; b.credit_in_vc[1] = 2'd2;
        tick(); clr();
        chk("p1_free_avail", 32'(b.vc_availability[6]), 1);
        chk("p1_free_ok", 32'(b.credit_ok[6]), 1);
        b.alloc_req[2] = 1'b1; b2.alloc_req[2] = 1'b1;
        tick(); tick(); clr();
        chk("p2_avail", 32'(b.vc_availability[11:8]), 32'b1100);
        chk("p2_avail_d2", 32'(b2.vc_availability[11:8]), 32'b1100);
        b.flit_send[2] = 1'b1; b.flit_send_vc[2] = 2'd1;
        b2.flit_send[2] = 1'b1; b2.flit_send_vc[2] = 2'd1;
        tick(); clr();
        chk("p2_ok_zero", 32'(b.credit_ok[9]), 0);
        chk("p2_ok_one_d2", 32'(b2.credit_ok[9]), 1);
        b.flit_send[2] = 1'b1; b.flit_send_vc[2] = 2'd1; b.credit_in[2] = 1'b1; b.credit_in_vc[2] = 2'd1;
        b2.flit_send[2] = 1'b1; b2.flit_send_vc[2] = 2'd1; b2.credit_in[2] = 1'b1; b2.credit_in_vc[2] = 2'd1;
        tick(); clr();
        chk("p2_sr_cnt0", 32'(b.credit_ok[9]), 0);
        chk("p2_sr_underflow", 32'(b.err_underflow), 1);
        chk("p2_sr_ok_d2", 32'(b2.credit_ok[9]), 1);
        chk("p2_sr_avail_d2", 32'(b2.vc_availability[9]), 0);
        chk("p2_sr_noerr_d2", 32'(b2.err_underflow), 0);
        b2.flit_send[2] = 1'b1; b2.flit_send_vc[2] = 2'd1;
        tick(); clr();
        chk("p2_last_credit_d2", 32'(b2.credit_ok[9]), 0);
        chk("p2_last_noerr_d2", 32'(b2.err_underflow), 0);
        b.credit_in[3] = 1'b1; b.credit_in_vc[3] = 2'd0;
        tick(); clr();
        chk("p3_overflow", 32'(b.err_overflow), 1);
        chk("p3_avail_held", 32'(b.vc_availability[12]), 1);
        chk("p3_ok_held", 32'(b.credit_ok[12]), 1);
        tick();
        chk("p3_overflow_sticky", 32'(b.err_overflow), 1);
        chk("underflow_sticky", 32'(b.err_underflow), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_overflow", 32'(b.err_overflow), 0);
        chk("rst_underflow", 32'(b.err_underflow), 0);
        chk("rst_avail", 32'(b.vc_availability), 32'hFFFFF);
        chk("rst_ok", 32'(b.credit_ok), 32'hFFFFF);
        b.alloc_req[4] = 1'b1;
        #1;
        chk("p4_gnt", 32'(b.alloc_gnt), 32'b10000);
        chk("p4_vc", 32'(b.alloc_vc[4]), 0);
        tick(); clr();
        chk("p4_active", 32'(b.vc_availability[16]), 0);
        chk("p4_ok", 32'(b.credit_ok[16]), 1);
        b.flit_send[4] = 1'b1; b.flit_send_vc[4] = 2'd0; b.flit_send_tail[4] = 1'b1;
        tick(); clr();
        chk("p4_free", 32'(b.vc_availability[16]), 1);
        chk("p4_ok_after", 32'(b.credit_ok[16]), 1);
        chk("p4_no_underflow", 32'(b.err_underflow), 0);
        b.flit_send[3] = 1'b1; b.flit_send_vc[3] = 2'd1;
        tick(); clr();
        chk("free_send_underflow", 32'(b.err_underflow), 1);
        chk("free_send_no_change", 32'(b.vc_availability[13]), 1);
        b.alloc_req = '1;
        reset = 1'b1;
        #1;
        chk("rst_gnt_blocked", 32'(b.alloc_gnt), 0);
        tick();
        reset = 1'b0;
        clr();
        #1;
        chk("rst_grant_avail", 32'(b.vc_availability), 32'hFFFFF);
        chk("rst_grant_err", 32'(b.err_underflow), 0);
        b.alloc_req = 5'b10011;
        #1;
        chk("post_rst_gnt", 32'(b.alloc_gnt), 32'b10011);
        chk("post_rst_p4_ptr", 32'(b.alloc_vc[4]), 0);
        tick(); clr();
        chk("post_rst_avail", 32'(b.vc_availability[7:0]), 32'hEE);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
